// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg.
// slave = the stage itself, master = the surrounding logic.
interface pipe_stage_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        pc_in;
  logic [WIDTH-1:0]        instruction_in;
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        pc_out;
  logic [WIDTH-1:0]        instruction_out;
  logic [NUM_CH*WIDTH-1:0] data_out;
  logic [CNT_W-1:0]        stall_count;

  modport slave (
    input  in_valid, pc_in, instruction_in, data_in,
    input  out_ready,
    output in_ready, out_valid,
    output pc_out, instruction_out, data_out,
    output stall_count
  );

  modport master (
    output in_valid, pc_in, instruction_in, data_in,
    output out_ready,
    input  in_ready, out_valid,
    input  pc_out, instruction_out, data_out,
    input  stall_count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage register with 2-entry skid buffer,
// flush-to-NOP and saturating stall counter.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_CH    = 2,
  parameter logic [WIDTH-1:0] NOP_INSTR = '0,
  parameter int               CNT_W     = 16
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  pipe_stage_reg_if.slave bus
);

  localparam int DW = NUM_CH * WIDTH;

  if (NUM_CH < 1 || WIDTH < 1) begin : g_illegal
    $error("pipe_stage_reg: NUM_CH and WIDTH must be >= 1");
  end

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_pc;
  logic [WIDTH-1:0] main_instr;
  logic [DW-1:0]    main_data;
  logic [WIDTH-1:0] skid_pc;
  logic [WIDTH-1:0] skid_instr;
  logic [DW-1:0]    skid_data;
  logic [CNT_W-1:0] stall_cnt;

  logic push;
  logic pop;
  logic stall;
  logic main_valid_n;
  logic skid_valid_n;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;
  logic nop_main;

  assign push  = bus.in_valid & ~skid_valid;
  assign pop   = main_valid & bus.out_ready;
  assign stall = bus.in_valid & skid_valid;

  // next occupancy and which register loads from where
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    nop_main     = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      nop_main     = 1'b1;
    end else begin
      case ({main_valid, skid_valid})
        2'b00: begin
          if (push) begin
            main_valid_n = 1'b1;
            ld_main_in   = 1'b1;
          end
        end
        2'b10: begin
          if (push && pop) begin
            ld_main_in = 1'b1;
          end else if (push) begin
            skid_valid_n = 1'b1;
            ld_skid      = 1'b1;
          end else if (pop) begin
            main_valid_n = 1'b0;
            nop_main     = 1'b1;
          end
        end
        2'b11: begin
          if (pop) begin
            skid_valid_n = 1'b0;
            ld_main_skid = 1'b1;
          end
        end
        default: begin
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
          nop_main     = 1'b1;
        end
      endcase
    end
  end

  // entry storage; main_instr is kept at NOP whenever main is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      main_data  <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      if (ld_main_in) begin
        main_pc    <= bus.pc_in;
        main_instr <= bus.instruction_in;
        main_data  <= bus.data_in;
      end else if (ld_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
        main_data  <= skid_data;
      end else if (nop_main) begin
        main_instr <= NOP_INSTR;
      end
      if (ld_skid) begin
        skid_pc    <= bus.pc_in;
        skid_instr <= bus.instruction_in;
        skid_data  <= bus.data_in;
      end
    end
  end

  // stall counter saturates; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready        = ~skid_valid;
  assign bus.out_valid       = main_valid;
  assign bus.pc_out          = main_pc;
  assign bus.instruction_out = main_instr;
  assign bus.data_out        = main_data;
  assign bus.stall_count     = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue reference model,
// directed scenarios plus randomized traffic.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush_s = 1'b0;
  logic flush_w = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32), .NUM_CH(2), .CNT_W(16)) bus ();
  pipe_stage_reg_if #(.WIDTH(32), .NUM_CH(2), .CNT_W(3))  bus_s ();
  pipe_stage_reg_if #(.WIDTH(16), .NUM_CH(4), .CNT_W(16)) bus_w ();

  pipe_stage_reg #(
    .WIDTH(32), .NUM_CH(2), .NOP_INSTR(NOP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(rst_n), .flush(flush), .bus(bus)
  );

  pipe_stage_reg #(
    .WIDTH(32), .NUM_CH(2), .NOP_INSTR(NOP), .CNT_W(3)
  ) dut_s (
    .clk(clk), .reset(rst_n), .flush(flush_s), .bus(bus_s)
  );

  pipe_stage_reg #(
    .WIDTH(16), .NUM_CH(4), .NOP_INSTR(16'h0), .CNT_W(16)
  ) dut_w (
    .clk(clk), .reset(rst_n), .flush(flush_w), .bus(bus_w)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  int unsigned m_stall = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // one clock of the main DUT; model follows the occupancy rules
  task automatic cyc(input logic iv, input logic ordy,
                     input logic fl, input logic [31:0] pc,
                     input logic [31:0] instr,
                     input logic [63:0] data);
    ent_t e;
    bit   do_pop;
    bit   do_push;
    bus.in_valid       = iv;
    bus.out_ready      = ordy;
    bus.pc_in          = pc;
    bus.instruction_in = instr;
    bus.data_in        = data;
    flush              = fl;
    @(posedge clk);
    do_pop  = (q.size() > 0) && ordy;
    do_push = iv && (q.size() < 2);
    if (iv && q.size() == 2 && m_stall < 65535) m_stall++;
    e.pc = pc; e.instr = instr; e.data = data;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
    end
    n_tests++;
    if (bus.pc_out !== 32'h0 || bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data pc %h data %h want 0", bus.pc_out, bus.data_out);
    end
    n_tests++;
    if (bus.instruction_out !== NOP || bus.stall_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_instr instr %h cnt %0d want %h 0",
               bus.instruction_out, bus.stall_count, NOP);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h100 + 32'(4 * i);
      cyc(1'b1, 1'b1, 1'b0, pc, 32'h2001_0005, {32'hB, 32'hA});
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.pc_out !== pc) begin
        n_fail++;
        $display("FAIL stream_pc v=%b pc %h want 1 %h", bus.out_valid, bus.pc_out, pc);
      end
      n_tests++;
      if (bus.instruction_out !== 32'h2001_0005 ||
          bus.data_out !== {32'hB, 32'hA} || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_body instr %h data %h rdy %b",
                 bus.instruction_out, bus.data_out, bus.in_ready);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.instruction_out !== NOP) begin
      n_fail++;
      $display("FAIL stream_drain v=%b instr %h want 0 %h",
               bus.out_valid, bus.instruction_out, NOP);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want_pc;
    int unsigned s0;
    s0 = m_stall;
    cyc(1'b1, 1'b0, 1'b0, 32'h200, 32'h11, 64'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h204, 32'h22, 64'h2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h208, 32'h33, 64'h3);
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.pc_out !== 32'h200) begin
        n_fail++;
        $display("FAIL bp_hold rdy %b pc %h want 0 200", bus.in_ready, bus.pc_out);
      end
      n_tests++;
      if (bus.stall_count !== 16'(s0 + i + 1)) begin
        n_fail++;
        $display("FAIL bp_stall got %0d want %0d", bus.stall_count, s0 + i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      want_pc = (i == 0) ? 32'h200 : 32'h204;
      n_tests++;
      if (i < 2 && (bus.out_valid !== 1'b1 || bus.pc_out !== want_pc)) begin
        n_fail++;
        $display("FAIL bp_order v=%b pc %h want 1 %h", bus.out_valid, bus.pc_out, want_pc);
      end else if (i == 2 && bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_empty v=%b want 0", bus.out_valid);
      end
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp_ready got %b want 1", bus.in_ready);
      end
    end
  endtask

  task automatic test_flush_full();
    cyc(1'b1, 1'b0, 1'b0, 32'h2F0, 32'h44, 64'h4);
    cyc(1'b1, 1'b0, 1'b0, 32'h2F4, 32'h55, 64'h5);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_prefull rdy %b want 0", bus.in_ready);
    end
    cyc(1'b1, 1'b0, 1'b1, 32'h300, 32'h66, 64'h6);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.instruction_out !== NOP) begin
      n_fail++;
      $display("FAIL flush_state v=%b rdy %b instr %h want 0 1 %h",
               bus.out_valid, bus.in_ready, bus.instruction_out, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak v=%b pc %h want 0", bus.out_valid, bus.pc_out);
      end
    end
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    for (int i = 0; i < 300; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      cyc(iv, ordy, fl, $urandom, $urandom, {$urandom, $urandom});
      n_tests++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rnd_flags cyc %0d v=%b rdy=%b want depth %0d",
                 i, bus.out_valid, bus.in_ready, q.size());
      end
      n_tests++;
      if (q.size() > 0) begin
        if (bus.pc_out !== q[0].pc || bus.instruction_out !== q[0].instr ||
            bus.data_out !== q[0].data) begin
          n_fail++;
          $display("FAIL rnd_head cyc %0d got %h %h %h want %h %h %h", i,
                   bus.pc_out, bus.instruction_out, bus.data_out,
                   q[0].pc, q[0].instr, q[0].data);
        end
      end else if (bus.instruction_out !== NOP) begin
        n_fail++;
        $display("FAIL rnd_nop cyc %0d instr %h want %h", i, bus.instruction_out, NOP);
      end
      n_tests++;
      if (bus.stall_count !== 16'(m_stall)) begin
        n_fail++;
        $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, bus.stall_count, m_stall);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 64'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h400, 32'h77, 64'h7);
    cyc(1'b1, 1'b0, 1'b0, 32'h404, 32'h88, 64'h8);
    cyc(1'b1, 1'b0, 1'b0, 32'h408, 32'h99, 64'h9);
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.stall_count === 16'h0) begin
      n_fail++;
      $display("FAIL arst_pre rdy %b cnt %0d want 0 nonzero", bus.in_ready, bus.stall_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_flags v=%b rdy %b want 0 1", bus.out_valid, bus.in_ready);
    end
    n_tests++;
    if (bus.pc_out !== 32'h0 || bus.data_out !== 64'h0 ||
        bus.instruction_out !== NOP || bus.stall_count !== 16'h0) begin
      n_fail++;
      $display("FAIL arst_regs pc %h data %h instr %h cnt %0d",
               bus.pc_out, bus.data_out, bus.instruction_out, bus.stall_count);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_stall = 0;
  endtask

  task automatic test_saturation();
    int want;
    bus_s.in_valid       = 1'b1;
    bus_s.out_ready      = 1'b0;
    bus_s.pc_in          = 32'h500;
    bus_s.instruction_in = 32'h1;
    bus_s.data_in        = 64'h1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      want = (i < 1) ? 0 : ((i - 1 > 7) ? 7 : i - 1);
      n_tests++;
      if (bus_s.stall_count !== 3'(want)) begin
        n_fail++;
        $display("FAIL sat_cnt cyc %0d got %0d want %0d", i, bus_s.stall_count, want);
      end
    end
    bus_s.in_valid = 1'b0;
  endtask

  task automatic test_param();
    logic [15:0] want;
    bus_w.in_valid       = 1'b1;
    bus_w.out_ready      = 1'b1;
    bus_w.pc_in          = 16'h0055;
    bus_w.instruction_in = 16'h1234;
    bus_w.data_in        = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(posedge clk);
    @(negedge clk);
    bus_w.in_valid = 1'b0;
    n_tests++;
    if (bus_w.out_valid !== 1'b1 || bus_w.pc_out !== 16'h0055 ||
        bus_w.instruction_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL wide_head v=%b pc %h instr %h", bus_w.out_valid,
               bus_w.pc_out, bus_w.instruction_out);
    end
    for (int k = 0; k < 4; k++) begin
      want = 16'((k + 1) * 16'h1111);
      n_tests++;
      if (bus_w.data_out[k*16 +: 16] !== want) begin
        n_fail++;
        $display("FAIL wide_ch%0d got %h want %h", k, bus_w.data_out[k*16 +: 16], want);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;   bus.out_ready = 1'b0;
    bus.pc_in = '0;        bus.instruction_in = '0;
    bus.data_in = '0;
    bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0;
    bus_s.pc_in = '0;      bus_s.instruction_in = '0;
    bus_s.data_in = '0;
    bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0;
    bus_w.pc_in = '0;      bus_w.instruction_in = '0;
    bus_w.data_in = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_random();
    test_async_reset();
    test_saturation();
    test_param();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed 4×32-bit inter-stage pipeline register.
- Carries PC, instruction and NUM_CH data operands between processor stages using a valid/ready handshake instead of a bare write enable.
- A 2-entry skid buffer lets the downstream stage stall without the ready path becoming combinational.
- Adds flush-to-NOP for branch/exception squash and a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 32: width of each data channel, of pc and of instruction.
- NUM_CH, 2: number of data operand channels (≥1).
- NOP_INSTR, 32'h00000000: instruction value presented when empty, flushed or in reset.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry.
- pc_in  input  WIDTH  upstream PC.
- instruction_in  input  WIDTH  upstream instruction.
- data_in  input  NUM_CH*WIDTH  operands, channel k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  pc_out/instruction_out/data_out are valid.
- out_ready  input  1  downstream accepts the entry.
- pc_out  output  WIDTH  head PC.
- instruction_out  output  WIDTH  head instruction.
- data_out  output  NUM_CH*WIDTH  head operands, same packing as data_in.
- stall_count  output  CNT_W  saturating count of upstream stall cycles.

Behaviour:
- Storage: main entry (drives outputs) plus one skid entry. Each entry holds pc, instruction, data and a valid bit.
- State is encoded by the valid bits:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Outputs are driven from registers only; no combinational path from inputs to outputs.
  - in_ready = ~skid_valid.
  - out_valid = main_valid.
- Transitions (no flush):
  - EMPTY, push → ONE. Main loads inputs; one-cycle latency in→out.
  - ONE, push & pop → ONE. Main loads the new inputs.
  - ONE, push & ~pop → FULL. Skid loads the inputs; main holds.
  - ONE, pop & ~push → EMPTY.
  - FULL, pop → ONE. Main loads skid; skid invalidates. No push is possible because in_ready=0.
  - Any state, no push and no pop → hold.
- Ordering: entries leave in arrival order. The skid entry never overtakes main.
- Held outputs: while out_valid=1 and out_ready=0, pc_out, instruction_out and data_out must not change.
- Empty presentation: when main is invalid, instruction_out = NOP_INSTR. pc_out and data_out hold their last values and are don't-care for checking.
- Flush (registered):
  - Both valid bits clear and main instruction is set to NOP_INSTR.
  - Any push in the same cycle is discarded; a pop in the same cycle still counts as completed for the downstream.
  - Next cycle: out_valid=0, in_ready=1.
- stall_count:
  - Increments each cycle in_valid=1 & in_ready=0.
  - Saturates at 2^CNT_W−1.
  - Flush does not clear it; only reset does.
- Reset (asynchronous, active-low), effective immediately on assertion, mid-transfer included:
  - Both valid bits = 0, so out_valid=0 and in_ready=1.
  - pc_out=0, data_out=0, instruction_out=NOP_INSTR, skid contents=0, stall_count=0.
  - Deassertion is used synchronously; the first push can occur on the first rising edge after deassertion.
- Widths: all data paths are pass-through. No arithmetic except stall_count.
- Legality (NUM_CH=0 or WIDTH=0): flag with a simulation-time error; the configuration is not supported.

Test Plan:
- Reset then stream:
  - Hold reset low 3 cycles, then release.
  - Push pc=0x100, instr=0x20010005, data={0xA,0xB} with out_ready=1 every cycle for 8 entries (pc +4 each).
  - Required: each entry appears one cycle later with out_valid=1 and in_ready constantly 1.
- Backpressure/skid:
  - Hold out_ready=0; push entries pc=0x200 then 0x204.
  - Required: in_ready drops after the second push, outputs hold 0x200, stall_count increments each cycle in_valid stays high.
  - Then raise out_ready: 0x200 then 0x204 emerge in order, in_ready returns to 1.
- Flush in FULL:
  - Fill both entries, assert flush together with a new push of pc=0x300.
  - Required next cycle: out_valid=0, instruction_out=NOP_INSTR, in_ready=1, 0x300 never appears.
- Async reset mid-operation:
  - Assert reset between clock edges while FULL.
  - Required immediately: out_valid=0, pc_out=0, data_out=0, instruction_out=NOP_INSTR, stall_count=0.
- Counter saturation:
  - Build with CNT_W=3; stall for 10 cycles.
  - Required: stall_count stops at 7.
- Parametrisation:
  - Build with WIDTH=16, NUM_CH=4; push data 0x1111/0x2222/0x3333/0x4444.
  - Required: each channel emerges unswapped at its own slice.
